// File: rtl/flash_reader_pkg.sv
// Shared types and constants for the flash burst reader slice.
package flash_reader_pkg;

   // Reader control states.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQUEST = 3'd1,
      RECEIVE = 3'd2,
      STREAM  = 3'd3,
      DONE    = 3'd4
   } state_t;

   // Avalon-MM burstcount port width.
   localparam int BURSTCOUNT_W = 6;

   // Counter widths: up to 32 words and 64 samples per burst.
   localparam int WORD_CNT_W   = 5;
   localparam int SAMPLE_CNT_W = 6;

endpackage

// File: rtl/sample_select.sv
// Maps a sample index to a word/half of the burst buffer, honoring the
// requested playback direction.
module sample_select
   import flash_reader_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int SAMPLE_W  = 16,
   parameter int BURST_LEN = 4
) (
   input  logic [BURST_LEN*DATA_W-1:0] words,
   input  logic [SAMPLE_CNT_W-1:0]     idx,
   input  logic                        reverse,
   output logic [SAMPLE_W-1:0]         sample
);

   localparam logic [SAMPLE_CNT_W-1:0] LAST_SAMPLE = SAMPLE_CNT_W'(2*BURST_LEN-1);

   logic [SAMPLE_CNT_W-1:0] eff;

   // Samples are packed low half first, so the effective index is the
   // sample position in the buffer; reverse mirrors it end-to-end.
   always_comb begin
      eff    = reverse ? (LAST_SAMPLE - idx) : idx;
      sample = '0;
      for (int i = 0; i < 2*BURST_LEN; i++) begin
         if (eff == SAMPLE_CNT_W'(i)) sample = words[i*SAMPLE_W +: SAMPLE_W];
      end
   end

endmodule

// File: rtl/flash_burst_reader.sv
// Fetches one Avalon-MM read burst from flash and streams the contained
// 16-bit samples to a ready/valid consumer, forward or reversed.
module flash_burst_reader
   import flash_reader_pkg::*;
#(
   parameter int ADDR_W    = 23,
   parameter int DATA_W    = 32,
   parameter int SAMPLE_W  = 16,
   parameter int BURST_LEN = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    reverse,
   input  logic [ADDR_W-1:0]       address_from_handler,
   output logic                    flash_mem_read,
   output logic                    flash_mem_write,
   output logic [ADDR_W-1:0]       flash_mem_address,
   output logic [BURSTCOUNT_W-1:0] flash_mem_burstcount,
   input  logic                    flash_mem_waitrequest,
   input  logic [DATA_W-1:0]       flash_mem_readdata,
   input  logic                    flash_mem_readdatavalid,
   output logic [SAMPLE_W-1:0]     sample_out,
   output logic                    sample_valid,
   input  logic                    sample_ready,
   output logic                    busy,
   output logic                    finish
);

   localparam logic [WORD_CNT_W-1:0]   LAST_WORD   = WORD_CNT_W'(BURST_LEN-1);
   localparam logic [SAMPLE_CNT_W-1:0] LAST_SAMPLE = SAMPLE_CNT_W'(2*BURST_LEN-1);

   state_t                     state;
   logic [WORD_CNT_W-1:0]      word_cnt;
   logic [SAMPLE_CNT_W-1:0]    sample_idx;
   logic [ADDR_W-1:0]          addr_q;
   logic                       rev_q;
   logic                       read_q;
   logic                       busy_q;
   logic                       finish_q;
   logic                       valid_q;
   logic [BURST_LEN*DATA_W-1:0] buf_q;
   logic [SAMPLE_W-1:0]        sel_sample;
   logic                       word_we;

   assign word_we = (state == RECEIVE) && flash_mem_readdatavalid;

   // Control FSM: request, collect the burst, stream samples, pulse finish.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         word_cnt   <= '0;
         sample_idx <= '0;
         addr_q     <= '0;
         rev_q      <= 1'b0;
         read_q     <= 1'b0;
         busy_q     <= 1'b0;
         finish_q   <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               finish_q <= 1'b0;
               if (start) begin
                  addr_q     <= address_from_handler;
                  rev_q      <= reverse;
                  word_cnt   <= '0;
                  sample_idx <= '0;
                  read_q     <= 1'b1;
                  busy_q     <= 1'b1;
                  state      <= REQUEST;
               end
            end
            REQUEST: begin
               if (!flash_mem_waitrequest) begin
                  read_q <= 1'b0;
                  state  <= RECEIVE;
               end
            end
            RECEIVE: begin
               if (flash_mem_readdatavalid) begin
                  if (word_cnt == LAST_WORD) begin
                     valid_q <= 1'b1;
                     state   <= STREAM;
                  end else begin
                     word_cnt <= word_cnt + 1'b1;
                  end
               end
            end
            STREAM: begin
               if (sample_ready) begin
                  if (sample_idx == LAST_SAMPLE) begin
                     valid_q  <= 1'b0;
                     finish_q <= 1'b1;
                     state    <= DONE;
                  end else begin
                     sample_idx <= sample_idx + 1'b1;
                  end
               end
            end
            DONE: begin
               finish_q <= 1'b0;
               busy_q   <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               read_q   <= 1'b0;
               busy_q   <= 1'b0;
               finish_q <= 1'b0;
               valid_q  <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   // Burst buffer; contents are only meaningful once STREAM is reached,
   // so it carries no reset.
   always_ff @(posedge clk) begin
      if (word_we) begin
         for (int w = 0; w < BURST_LEN; w++) begin
            if (word_cnt == WORD_CNT_W'(w)) buf_q[w*DATA_W +: DATA_W] <= flash_mem_readdata;
         end
      end
   end

   sample_select #(
      .DATA_W    (DATA_W),
      .SAMPLE_W  (SAMPLE_W),
      .BURST_LEN (BURST_LEN)
   ) u_sample_select (
      .words   (buf_q),
      .idx     (sample_idx),
      .reverse (rev_q),
      .sample  (sel_sample)
   );

   assign flash_mem_read       = read_q;
   assign flash_mem_write      = 1'b0;
   assign flash_mem_address    = addr_q;
   assign flash_mem_burstcount = BURSTCOUNT_W'(BURST_LEN);
   assign busy                 = busy_q;
   assign finish               = finish_q;
   assign sample_valid         = valid_q;
   // Buffer is uncleared, so the sample is forced to zero outside STREAM.
   assign sample_out           = valid_q ? sel_sample : '0;

endmodule

// File: tb/tb_flash_burst_reader.sv
// Scoreboard bench for flash_burst_reader: expected samples are queued as
// burst words are driven and compared as the consumer accepts them.
module tb_flash_burst_reader;

   localparam int ADDR_W    = 23;
   localparam int DATA_W    = 32;
   localparam int SAMPLE_W  = 16;
   localparam int BURST_LEN = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic                reverse;
   logic [ADDR_W-1:0]   address_from_handler;
   logic                flash_mem_read;
   logic                flash_mem_write;
   logic [ADDR_W-1:0]   flash_mem_address;
   logic [5:0]          flash_mem_burstcount;
   logic                flash_mem_waitrequest;
   logic [DATA_W-1:0]   flash_mem_readdata;
   logic                flash_mem_readdatavalid;
   logic [SAMPLE_W-1:0] sample_out;
   logic                sample_valid;
   logic                sample_ready;
   logic                busy;
   logic                finish;

   int total = 0;
   int bad   = 0;
   logic [SAMPLE_W-1:0] exp_q[$];

   always #5 clk = ~clk;

   flash_burst_reader #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .SAMPLE_W  (SAMPLE_W),
      .BURST_LEN (BURST_LEN)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .start                   (start),
      .reverse                 (reverse),
      .address_from_handler    (address_from_handler),
      .flash_mem_read          (flash_mem_read),
      .flash_mem_write         (flash_mem_write),
      .flash_mem_address       (flash_mem_address),
      .flash_mem_burstcount    (flash_mem_burstcount),
      .flash_mem_waitrequest   (flash_mem_waitrequest),
      .flash_mem_readdata      (flash_mem_readdata),
      .flash_mem_readdatavalid (flash_mem_readdatavalid),
      .sample_out              (sample_out),
      .sample_valid            (sample_valid),
      .sample_ready            (sample_ready),
      .busy                    (busy),
      .finish                  (finish)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_read"},   64'(flash_mem_read), 64'd0);
      check({tag, "_write"},  64'(flash_mem_write), 64'd0);
      check({tag, "_valid"},  64'(sample_valid), 64'd0);
      check({tag, "_busy"},   64'(busy), 64'd0);
      check({tag, "_finish"}, 64'(finish), 64'd0);
      check({tag, "_sample"}, 64'(sample_out), 64'd0);
      check({tag, "_addr"},   64'(flash_mem_address), 64'd0);
   endtask

   // One full burst: request (optional waitstates), words (optional gap),
   // stream (optional consumer stall, optional stray start), finish.
   task automatic run_burst(input logic [ADDR_W-1:0] addr, input bit rev, input bit fixed,
                            input int wait_n, input int gap_at, input int stall_at,
                            input int stall_len, input bit poke_start);
      logic [DATA_W-1:0]   words[BURST_LEN];
      logic [SAMPLE_W-1:0] seq[2*BURST_LEN];
      int cyc;
      for (int w = 0; w < BURST_LEN; w++) begin
         if (fixed) words[w] = {16'(2*w+2), 16'(2*w+1)};
         else       words[w] = $urandom;
         seq[2*w]   = words[w][SAMPLE_W-1:0];
         seq[2*w+1] = words[w][DATA_W-1:SAMPLE_W];
      end
      for (int i = 0; i < 2*BURST_LEN; i++)
         exp_q.push_back(rev ? seq[2*BURST_LEN-1-i] : seq[i]);

      start = 1'b1;
      reverse = rev;
      address_from_handler = addr;
      flash_mem_waitrequest = (wait_n > 0);
      tick();
      start = 1'b0;
      reverse = ~rev;
      address_from_handler = ~addr;
      check("busy_req", 64'(busy), 64'd1);
      check("burstcount", 64'(flash_mem_burstcount), 64'(BURST_LEN));
      for (int i = 0; i < wait_n; i++) begin
         check("read_wait", 64'(flash_mem_read), 64'd1);
         check("addr_wait", 64'(flash_mem_address), 64'(addr));
         tick();
      end
      flash_mem_waitrequest = 1'b0;
      check("read_acc", 64'(flash_mem_read), 64'd1);
      check("addr_acc", 64'(flash_mem_address), 64'(addr));
      tick();
      check("read_drop", 64'(flash_mem_read), 64'd0);

      for (int w = 0; w < BURST_LEN; w++) begin
         if (w == gap_at) begin
            flash_mem_readdatavalid = 1'b0;
            tick();
         end
         flash_mem_readdatavalid = 1'b1;
         flash_mem_readdata = words[w];
         tick();
      end
      flash_mem_readdatavalid = 1'b0;
      flash_mem_readdata = 32'hDEAD_BEEF;

      cyc = 0;
      while (exp_q.size() > 0 && cyc < 100) begin
         sample_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
         start = poke_start && (cyc == 2);
         address_from_handler = ADDR_W'($urandom);
         check("valid_stream", 64'(sample_valid), 64'd1);
         if (sample_ready) check("sample", 64'(sample_out), 64'(exp_q.pop_front()));
         else              check("sample_hold", 64'(sample_out), 64'(exp_q[0]));
         tick();
         cyc++;
      end
      start = 1'b0;
      sample_ready = 1'b1;
      if (exp_q.size() != 0) begin
         check("stream_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
      check("finish_pulse", 64'(finish), 64'd1);
      check("busy_done", 64'(busy), 64'd1);
      check("valid_done", 64'(sample_valid), 64'd0);
      tick();
      check("finish_clear", 64'(finish), 64'd0);
      check("busy_idle", 64'(busy), 64'd0);
      tick();
      check("finish_once", 64'(finish), 64'd0);
      check("idle_stays", 64'(busy), 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      reverse = 1'b0;
      address_from_handler = '0;
      flash_mem_waitrequest = 1'b0;
      flash_mem_readdata = '0;
      flash_mem_readdatavalid = 1'b0;
      sample_ready = 1'b1;
      tick();
      tick();
      check_reset_outputs("por");
      rst = 1'b0;
      tick();
      check_reset_outputs("idle");

      // Forward then reverse, fixed data, no stalls.
      run_burst(23'd1001, 1'b0, 1'b1, 0, -1, -1, 0, 1'b0);
      run_burst(23'd1001, 1'b1, 1'b1, 0, -1, -1, 0, 1'b0);
      // Waitstates in REQUEST.
      run_burst(23'h5_A5A5, 1'b0, 1'b0, 5, -1, -1, 0, 1'b0);
      // Consumer stall mid-stream, with a gap in readdatavalid.
      run_burst(23'h12_3456, 1'b0, 1'b0, 1, 2, 3, 3, 1'b0);
      run_burst(23'h7F_FFFF, 1'b1, 1'b0, 0, 1, 4, 3, 1'b0);
      // Stray start during STREAM.
      run_burst(23'h00_0042, 1'b0, 1'b0, 0, -1, -1, 0, 1'b1);

      // Reset after two of four words.
      start = 1'b1;
      address_from_handler = 23'h33_3333;
      tick();
      start = 1'b0;
      tick();
      flash_mem_readdatavalid = 1'b1;
      flash_mem_readdata = 32'h1111_1111;
      tick();
      flash_mem_readdata = 32'h2222_2222;
      tick();
      rst = 1'b1;
      flash_mem_readdata = 32'h3333_3333;
      tick();
      rst = 1'b0;
      check_reset_outputs("mid_rst");
      flash_mem_readdata = 32'h4444_4444;
      tick();
      tick();
      flash_mem_readdatavalid = 1'b0;
      check("late_busy", 64'(busy), 64'd0);
      check("late_valid", 64'(sample_valid), 64'd0);
      check("late_read", 64'(flash_mem_read), 64'd0);
      run_burst(23'h0A_BCDE, 1'b1, 1'b0, 2, -1, 1, 2, 1'b0);
      run_burst(23'h01_0000, 1'b0, 1'b1, 0, -1, -1, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute guard so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout got=%0d want=0", 1);
      $fatal(1, "timeout");
   end

endmodule
